// File: rtl/fhe_acc_pkg.sv
// Shared types for the FHE accelerator output path: writer FSM states and line geometry.
// Default geometry is used when a block is instantiated without overrides.
package fhe_acc_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_LINE_SIZE = 4;
  localparam int LINE_W        = DEF_BIT_WIDTH * DEF_LINE_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_STREAM,
    ST_FLUSH,
    ST_COMMIT
  } wr_state_e;

endpackage

// File: rtl/rlwe_line_reg.sv
// Registered write stage: one cycle from an accepted line to the FIFO write strobe/addr/data.
// No backpressure of its own; it follows the handshake it is given.
module rlwe_line_reg
  import fhe_acc_pkg::*;
#(
  parameter int LW = LINE_W,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [1:0][LW-1:0]   data_i,
  output logic [1:0]           en_o,
  output logic [AW-1:0]        addr_o,
  output logic [1:0][LW-1:0]   data_o
);

  logic               en_q;
  logic [AW-1:0]      addr_q;
  logic [1:0][LW-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q <= wr_i;
      if (wr_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign en_o   = {2{en_q}};
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/rlwe_output_writer.sv
// Streams A/B line pairs of each RLWE ciphertext into reserved FIFO slots, then commits the slot.
// Writes land one cycle after the handshake; in_ready drops while waiting for a free slot.
module rlwe_output_writer
  import fhe_acc_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int LINE_SIZE   = DEF_LINE_SIZE,
  parameter int LINE_ADDR_W = 8,
  parameter int CNT_W       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     num_rlwe,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [1:0][BIT_WIDTH*LINE_SIZE-1:0]  in_data,
  input  logic [1:0]                           fifo_full,
  output logic [1:0]                           wr_enable,
  output logic [LINE_ADDR_W-1:0]               wr_addr,
  output logic [1:0][BIT_WIDTH*LINE_SIZE-1:0]  wr_data,
  output logic [1:0]                           wr_commit,
  output logic                                 busy,
  output logic                                 done
);

  wr_state_e              state_q, state_d;
  logic [LINE_ADDR_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic                   zero_done_q, zero_done_d;
  logic                   hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_cnt_q  <= '0;
      remaining_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      remaining_q <= remaining_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b1;
    wr_commit   = 2'b00;
    done        = zero_done_q;
    hs          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_rlwe != '0) begin
            state_d     = ST_WAIT_SLOT;
            remaining_d = num_rlwe;
            line_cnt_d  = '0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      ST_WAIT_SLOT: begin
        if (fifo_full == 2'b00) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        hs       = in_valid;
        if (in_valid) begin
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == '1) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        wr_commit   = 2'b11;
        remaining_d = remaining_q - CNT_W'(1);
        // Last ciphertext: done rides on the same cycle as the commit pulse.
        if (remaining_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SLOT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  rlwe_line_reg #(
    .LW(BIT_WIDTH * LINE_SIZE),
    .AW(LINE_ADDR_W)
  ) u_line_reg (
    .clk   (clk),
    .rst   (rst),
    .wr_i  (hs),
    .addr_i(line_cnt_q),
    .data_i(in_data),
    .en_o  (wr_enable),
    .addr_o(wr_addr),
    .data_o(wr_data)
  );

endmodule

// File: tb/tb_rlwe_output_writer.sv
// Directed bench for rlwe_output_writer with 4 lines per polynomial.
module tb_rlwe_output_writer;

  localparam int BW = 16;
  localparam int LS = 4;
  localparam int AW = 2;
  localparam int CW = 16;
  localparam int LW = BW * LS;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CW-1:0]       num_rlwe;
  logic                in_valid;
  logic                in_ready;
  logic [1:0][LW-1:0]  in_data;
  logic [1:0]          fifo_full;
  logic [1:0]          wr_enable;
  logic [AW-1:0]       wr_addr;
  logic [1:0][LW-1:0]  wr_data;
  logic [1:0]          wr_commit;
  logic                busy;
  logic                done;

  rlwe_output_writer #(
    .BIT_WIDTH(BW), .LINE_SIZE(LS), .LINE_ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rlwe(num_rlwe),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fifo_full(fifo_full), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_commit(wr_commit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   seq;
  int   mode;
  bit   tog;
  bit   hs_q;
  int   cyc_n = 0;
  bit   busy_seen;
  int   w_addr[$];
  logic [127:0] w_dat[$];
  int   w_cyc[$];
  int   c_cyc[$];
  int   d_cyc[$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input int k);
    logic [63:0] a;
    logic [63:0] b;
    a = 64'hA0A0_0000_0000_0000 | 64'(k);
    b = 64'hB0B0_0000_0000_0000 ^ (64'(k) * 64'h0001_0001_0001_0001);
    return {b, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    w_addr.delete();
    w_dat.delete();
    w_cyc.delete();
    c_cyc.delete();
    d_cyc.delete();
    busy_seen = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    check_eq({tag, "_wr_enable"}, wr_enable, 0);
    check_eq({tag, "_wr_commit"}, wr_commit, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic run_start(input int num, output int s_cyc);
    start    = 1'b1;
    num_rlwe = CW'(num);
    s_cyc    = cyc_n;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (d_cyc.size() == 0 && n < bound) begin
      cyc();
      n++;
    end
    check_eq("done_seen", d_cyc.size(), 1);
  endtask

  task automatic check_poly(input string tag, input int base, input int line_base, input int gap);
    check_eq({tag, "_count"}, w_addr.size() >= base + 4, 1);
    if (w_addr.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq({tag, "_addr"}, w_addr[base+i], i);
        check_eq({tag, "_data"}, w_dat[base+i], line_of(line_base + i));
        if (i > 0) check_eq({tag, "_gap"}, w_cyc[base+i] - w_cyc[base+i-1], gap);
      end
    end
  endtask

  // Driver: advances the line sequence on each observed handshake.
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    seq      = 0;
    mode     = 0;
    tog      = 1'b0;
    forever begin
      @(posedge clk);
      cyc_n++;
      if (hs_q) seq++;
      #2;
      tog      = ~tog;
      in_valid = (mode == 1) || (mode == 2 && tog);
      in_data  = line_of(seq);
    end
  end

  // Monitor: logs writes/commits/done and checks each strobe follows a handshake.
  initial begin
    hs_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_q = 1'b0;
      end else begin
        check_eq("wr_enable_follows_hs", wr_enable, hs_q ? 128'd3 : 128'd0);
        if (wr_enable != 2'b00) begin
          w_addr.push_back(int'(wr_addr));
          w_dat.push_back(wr_data);
          w_cyc.push_back(cyc_n);
        end
        if (wr_commit != 2'b00) begin
          check_eq("commit_value", wr_commit, 3);
          check_eq("commit_vs_wr", wr_enable, 0);
          c_cyc.push_back(cyc_n);
        end
        if (done) d_cyc.push_back(cyc_n);
        if (busy) busy_seen = 1'b1;
        hs_q = in_valid && in_ready;
      end
    end
  end

  initial begin
    int s;
    int t;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    num_rlwe  = '0;
    fifo_full = 2'b00;
    busy_seen = 1'b0;
    repeat (2) cyc();
    chk_reset_outs("reset");
    rst = 1'b0;
    repeat (2) cyc();

    // Single ciphertext, continuous valid.
    clear_logs();
    seq  = 0;
    mode = 1;
    run_start(1, s);
    wait_done(100);
    check_poly("j1", 0, 0, 1);
    check_eq("j1_first_wr_latency", (w_cyc.size() > 0) ? w_cyc[0] - s : -1, 3);
    check_eq("j1_commits", c_cyc.size(), 1);
    if (c_cyc.size() == 1 && w_cyc.size() == 4) begin
      check_eq("j1_commit_cycle", c_cyc[0] - w_cyc[3], 1);
      check_eq("j1_done_with_commit", d_cyc[0], c_cyc[0]);
    end
    check_eq("j1_busy_after", busy, 0);
    check_eq("j1_done_after", done, 0);
    repeat (3) cyc();

    // Two ciphertexts, FIFO A full for 5 cycles after the first commit.
    clear_logs();
    seq = 0;
    run_start(2, s);
    n = 0;
    while (c_cyc.size() == 0 && n < 100) begin
      cyc();
      n++;
    end
    check_eq("j2_first_commit", c_cyc.size(), 1);
    fifo_full = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("j2_stall_in_ready", in_ready, 0);
      check_eq("j2_stall_busy", busy, 1);
      cyc();
    end
    fifo_full = 2'b00;
    t = cyc_n;
    check_eq("j2_no_wr_during_stall", w_addr.size(), 4);
    wait_done(100);
    repeat (5) cyc();
    check_poly("j2_p0", 0, 0, 1);
    check_poly("j2_p1", 4, 4, 1);
    check_eq("j2_resume_latency", (w_cyc.size() > 4) ? w_cyc[4] - t : -1, 2);
    check_eq("j2_commits", c_cyc.size(), 2);
    check_eq("j2_dones", d_cyc.size(), 1);
    if (c_cyc.size() == 2 && d_cyc.size() == 1) check_eq("j2_done_cycle", d_cyc[0], c_cyc[1]);

    // Bubbles: valid toggles every cycle.
    clear_logs();
    seq  = 0;
    mode = 2;
    run_start(1, s);
    wait_done(100);
    check_poly("j3", 0, 0, 2);
    check_eq("j3_commits", c_cyc.size(), 1);
    mode = 1;
    repeat (3) cyc();

    // Zero-length job.
    clear_logs();
    run_start(0, s);
    repeat (4) cyc();
    check_eq("j4_dones", d_cyc.size(), 1);
    if (d_cyc.size() > 0) check_eq("j4_done_cycle", d_cyc[0] - s, 1);
    check_eq("j4_writes", w_addr.size(), 0);
    check_eq("j4_commits", c_cyc.size(), 0);
    check_eq("j4_busy_seen", busy_seen, 0);

    // Reset mid-job after two lines, then a clean job.
    clear_logs();
    seq = 0;
    run_start(1, s);
    n = 0;
    while (w_addr.size() < 2 && n < 50) begin
      cyc();
      n++;
    end
    check_eq("j5_two_lines", w_addr.size() >= 2, 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    check_eq("j5_no_commit", c_cyc.size(), 0);
    check_eq("j5_no_done", d_cyc.size(), 0);
    repeat (2) cyc();
    seq = 0;
    rst = 1'b0;
    cyc();
    clear_logs();
    run_start(1, s);
    wait_done(100);
    check_poly("j5_after", 0, 0, 1);
    check_eq("j5_commits", c_cyc.size(), 1);
    repeat (3) cyc();

    // start during STREAM is ignored.
    clear_logs();
    seq = 0;
    run_start(2, s);
    n = 0;
    while (w_addr.size() < 1 && n < 50) begin
      cyc();
      n++;
    end
    check_eq("j6_in_stream", in_ready, 1);
    start    = 1'b1;
    num_rlwe = CW'(5);
    cyc();
    start = 1'b0;
    wait_done(200);
    repeat (20) cyc();
    check_eq("j6_writes", w_addr.size(), 8);
    check_eq("j6_commits", c_cyc.size(), 2);
    check_eq("j6_dones", d_cyc.size(), 1);
    check_eq("j6_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
